gf163_mul_seq: RTL and testbench
================================

GF163_MUL_SEQ -- requirements
Module: gf163_mul_seq

Interface
REQ-001 SHALL: clk  input  1  single clock; every register updates on its rising edge.
REQ-002 SHALL: rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-003 SHALL: start  input  1  request to multiply; single-cycle pulse or level.
REQ-004 SHALL: a  input  163  operand A(x); bit i is the coefficient of x^i.
REQ-005 SHALL: b  input  163  operand B(x); same bit order as a.
REQ-006 SHALL: busy  output  1  high while an operation is in progress.
REQ-007 SHALL: done  output  1  one-cycle pulse when c becomes valid.
REQ-008 SHALL: c  output  325  result polynomial; bit i is the coefficient of x^i.

Function
REQ-009 SHALL: split each operand into 4 digits of 41 bits (digit k = bits 41k+40:41k), zero-extending bit 163.
REQ-010 SHALL: compute all GF(2)[x] products with a single shared karatsuba41 instance.
- Inputs: 41-bit digits.
- Output: 81-bit carry-less product.
REQ-011 SHALL: use the FSM states IDLE, MUL, RED, DONE.
REQ-012 SHALL: accept start only in IDLE or DONE.
- On the accepting edge, capture a and b into registers.
- Clear the 328-bit accumulator.
- Set i=j=0 and enter MUL.
- Assert busy from the next cycle.
REQ-013 SHALL: ignore start while in MUL or RED, with no side effects.
REQ-014 SHALL: in MUL, take 16 cycles, one digit product per cycle, in order i outer 0..3, j inner 0..3.
- Each cycle, XOR a_i*b_j shifted left by 41*(i+j) into the accumulator.
REQ-015 SHALL: after the (i=3, j=3) product, go to RED if reduction is compiled in (REQ-023); otherwise go directly to DONE.
REQ-016 SHALL: in RED, reduce the accumulator modulo f(x)=x^163+x^7+x^6+x^3+1 in one cycle.
- c[162:0] = remainder.
- c[324:163] = 0.
REQ-017 SHALL: in DONE, assert done for exactly that cycle, deassert busy, and return to IDLE unless start is accepted (REQ-012).
REQ-018 SHALL: latency from the accepting edge to done high.
- 18 cycles with reduction.
- 17 cycles without.
REQ-019 SHALL: update c only on entry to DONE and hold it until the next DONE or reset.
REQ-020 SHALL: carry no state between operations (accumulator cleared on every start).

Reset
REQ-021 SHALL: on rst, within the same edge:
- state=IDLE;
- busy=0, done=0, c=0;
- accumulator, counters and operand registers = 0.
REQ-022 SHALL: on rst during MUL or RED, abandon the operation, produce no done pulse, and keep c=0.

Configuration
REQ-023 SHALL: when GF163_REDUCE_EN is defined, include RED and output the reduced field element per REQ-016.
REQ-024 SHALL: when GF163_REDUCE_EN is undefined:
- omit RED and the reduction logic;
- c = raw 325-bit product (accumulator bits 324:0);
- latency = 17 cycles.

Structure
REQ-025 SHALL: place these constants in the shared package gf163_pkg:
- M=163, DIGIT_W=41, NDIG=4, PROD_W=325, ACC_W=328;
- reduction polynomial constant;
- FSM state enumeration.
REQ-026 SHALL: instantiate exactly one sub-module, karatsuba41, unmodified; digit selection and accumulation stay in this block.

Verification
REQ-027 SHALL (reduction on): a=1, b=1, start pulse -> done 18 cycles later, c=1, busy high on cycles 1..17.
REQ-028 SHALL (reduction on): a=x^162, b=x -> c=0xC9 (x^7+x^6+x^3+1), upper bits 0.
REQ-029 SHALL (reduction off): a=x^162, b=x^162 -> c has only bit 324 set, done at cycle 17.
REQ-030 SHALL: start re-pulsed at cycles 3 and 10 of an operation -> ignored; single done, correct c.
- Start asserted in the DONE cycle -> accepted back-to-back; second done 18 cycles later.
REQ-031 SHALL: rst asserted at cycle 8 of MUL -> next cycle busy=0, c=0; no done pulse follows.
REQ-032 SHALL: 1000 random operand pairs -> c matches a bit-serial software model of carry-less multiply plus mod f(x).

Source files
------------

// File: rtl/gf163_pkg.sv
// Shared constants, FSM encoding and field reduction for the GF(2^163) digit-serial multiplier.
// Define GF163_REDUCE_EN to include the RED state and the mod f(x) reduction.
package gf163_pkg;

    localparam int M       = 163;
    localparam int DIGIT_W = 41;
    localparam int NDIG    = 4;
    localparam int PROD_W  = 325;
    localparam int ACC_W   = 328;

    // f(x) = x^163 + x^7 + x^6 + x^3 + 1
    localparam logic [M:0] POLY = {1'b1, {(M-8){1'b0}}, 8'hC9};

    typedef enum logic [1:0] {
        IDLE,
        MUL,
`ifdef GF163_REDUCE_EN
        RED,
`endif
        DONE
    } state_t;

    // Two folds of x^163 = x^7+x^6+x^3+1: the first leaves at most 7 bits above x^162,
    // and the second cannot overflow again.
    function automatic logic [PROD_W-1:0] gf163_reduce(input logic [PROD_W-1:0] p);
        logic [PROD_W-M-1:0] hi;
        logic [M+6:0]        t;
        logic [6:0]          h2;
        logic [M-1:0]        r;
        hi = p[PROD_W-1:M];
        t  = {7'b0, p[M-1:0]};
        for (int k = 0; k < 8; k++)
            if (POLY[k]) t = t ^ ({8'b0, hi} << k);
        h2 = t[M+6:M];
        r  = t[M-1:0];
        for (int k = 0; k < 8; k++)
            if (POLY[k]) r = r ^ ({{(M-7){1'b0}}, h2} << k);
        return {{(PROD_W-M){1'b0}}, r};
    endfunction

endpackage

// File: rtl/karatsuba41.sv
// Combinational 41x41 carry-less multiplier, one Karatsuba level over 21/20-bit halves.
module karatsuba41 (
    input  logic [40:0] x,
    input  logic [40:0] y,
    output logic [80:0] p
);

    function automatic logic [40:0] clmul21(input logic [20:0] u, input logic [20:0] v);
        logic [40:0] r;
        r = '0;
        for (int k = 0; k < 21; k++)
            if (v[k]) r = r ^ ({20'b0, u} << k);
        return r;
    endfunction

    logic [40:0] z0, z2, zm, mid;

    assign z0  = clmul21(x[20:0], y[20:0]);
    assign z2  = clmul21({1'b0, x[40:21]}, {1'b0, y[40:21]});
    assign zm  = clmul21(x[20:0] ^ {1'b0, x[40:21]}, y[20:0] ^ {1'b0, y[40:21]});
    assign mid = zm ^ z0 ^ z2;

    assign p = {40'b0, z0} ^ ({40'b0, mid} << 21) ^ ({40'b0, z2} << 42);

endmodule

// File: rtl/gf163_mul_seq.sv
// Digit-serial GF(2)[x] multiplier for 163-bit operands: 16 digit products through one karatsuba41.
// With GF163_REDUCE_EN defined the product is reduced mod f(x) in an extra RED cycle.
module gf163_mul_seq
    import gf163_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [M-1:0]      a,
    input  logic [M-1:0]      b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] c
);

    localparam int PP_W = 2*DIGIT_W - 1;

    state_t              state, state_nxt;
    logic [M-1:0]        a_q, b_q;
    logic [ACC_W-1:0]    acc, acc_nxt;
    logic [1:0]          i_q, j_q, i_nxt, j_nxt;
    logic [PROD_W-1:0]   c_nxt;
    logic                accept;
    logic [2:0]          ij_sum;
    logic [NDIG*DIGIT_W-1:0] a_ext, b_ext;
    logic [DIGIT_W-1:0]  a_dig, b_dig;
    logic [PP_W-1:0]     prod;
    logic                acc_unused;

    // Operands padded to a whole number of digits (bit 163 is always zero)
    assign a_ext  = {{(NDIG*DIGIT_W-M){1'b0}}, a_q};
    assign b_ext  = {{(NDIG*DIGIT_W-M){1'b0}}, b_q};
    assign a_dig  = a_ext[DIGIT_W*i_q +: DIGIT_W];
    assign b_dig  = b_ext[DIGIT_W*j_q +: DIGIT_W];
    assign ij_sum = {1'b0, i_q} + {1'b0, j_q};

    karatsuba41 u_kara (
        .x (a_dig),
        .y (b_dig),
        .p (prod)
    );

    assign accept     = start && (state == IDLE || state == DONE);
    assign done       = (state == DONE);
`ifdef GF163_REDUCE_EN
    assign busy       = (state == MUL) || (state == RED);
`else
    assign busy       = (state == MUL);
`endif
    assign acc_unused = ^acc[ACC_W-1:PROD_W];

    always_comb begin
        state_nxt = state;
        i_nxt     = i_q;
        j_nxt     = j_q;
        acc_nxt   = acc;
        c_nxt     = c;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (accept) begin
                    state_nxt = MUL;
                    i_nxt     = 2'd0;
                    j_nxt     = 2'd0;
                    acc_nxt   = '0;
                end
            end
            MUL: begin
                acc_nxt[DIGIT_W*ij_sum +: PP_W] = acc[DIGIT_W*ij_sum +: PP_W] ^ prod;
                j_nxt = j_q + 2'd1;
                if (j_q == 2'd3) i_nxt = i_q + 2'd1;
                if (i_q == 2'd3 && j_q == 2'd3) begin
`ifdef GF163_REDUCE_EN
                    state_nxt = RED;
`else
                    state_nxt = DONE;
                    c_nxt     = acc_nxt[PROD_W-1:0];
`endif
                end
            end
`ifdef GF163_REDUCE_EN
            RED: begin
                state_nxt = DONE;
                c_nxt     = gf163_reduce(acc[PROD_W-1:0]);
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            i_q   <= 2'd0;
            j_q   <= 2'd0;
            c     <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            i_q   <= i_nxt;
            j_q   <= j_nxt;
            c     <= c_nxt;
            if (accept) begin
                a_q <= a;
                b_q <= b;
            end
        end
    end

endmodule

// File: tb/tb_gf163_mul_seq.sv
// Self-checking bench for gf163_mul_seq against a bit-serial carry-less multiply / long-division model.
module tb_gf163_mul_seq;

`ifdef GF163_REDUCE_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 17;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [162:0] a = '0;
    logic [162:0] b = '0;
    logic         busy;
    logic         done;
    logic [324:0] c;

    int n_cmp = 0;
    int n_bad = 0;

    gf163_mul_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .c     (c)
    );

    always #5 clk = ~clk;

    function automatic logic [324:0] clmul(input logic [162:0] x, input logic [162:0] y);
        logic [324:0] r;
        r = '0;
        for (int k = 0; k < 163; k++)
            if (y[k]) r = r ^ ({162'b0, x} << k);
        return r;
    endfunction

    function automatic logic [324:0] mod_f(input logic [324:0] p);
        logic [324:0] f;
        f = '0;
        f[163] = 1'b1; f[7] = 1'b1; f[6] = 1'b1; f[3] = 1'b1; f[0] = 1'b1;
        for (int k = 324; k >= 163; k--)
            if (p[k]) p = p ^ (f << (k - 163));
        return p;
    endfunction

    function automatic logic [324:0] ref_mul(input logic [162:0] x, input logic [162:0] y);
`ifdef GF163_REDUCE_EN
        return mod_f(clmul(x, y));
`else
        return clmul(x, y);
`endif
    endfunction

    function automatic logic [162:0] rnd163();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[162:0];
    endfunction

    // Drives one start pulse and waits (bounded) for done; leaves the bench inside the DONE cycle.
    task automatic do_op(input logic [162:0] aa, input logic [162:0] bb,
                         output logic [324:0] cc, output int lat, output int busy_err);
        start = 1'b1; a = aa; b = bb;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; busy_err = 0; cc = 'x;
        for (int n = 1; n <= 40; n++) begin
            if (done) begin
                lat = n; cc = c;
                if (busy) busy_err++;
                break;
            end
            if (!busy) busy_err++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
        n_cmp++; if (c !== '0) begin n_bad++; $display("FAIL reset_c got=%h want=0", c); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fixed();
        logic [324:0] cc, exp;
        int lat, be;
        do_op(163'd1, 163'd1, cc, lat, be);
        exp = 325'd1;
        n_cmp++; if (cc !== exp) begin n_bad++; $display("FAIL one_times_one got=%h want=%h", cc, exp); end
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL one_latency got=%0d want=%0d", lat, LAT); end
        n_cmp++; if (be !== 0) begin n_bad++; $display("FAIL one_busy_window errors=%0d want=0", be); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width got=%b want=0", done); end
        n_cmp++; if (c !== exp) begin n_bad++; $display("FAIL c_hold got=%h want=%h", c, exp); end
`ifdef GF163_REDUCE_EN
        do_op(163'd1 << 162, 163'd2, cc, lat, be);
        exp = 325'hC9;
        n_cmp++; if (cc !== exp) begin n_bad++; $display("FAIL x162_times_x got=%h want=%h", cc, exp); end
`else
        do_op(163'd1 << 162, 163'd1 << 162, cc, lat, be);
        exp = '0; exp[324] = 1'b1;
        n_cmp++; if (cc !== exp) begin n_bad++; $display("FAIL x162_squared got=%h want=%h", cc, exp); end
`endif
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL edge_latency got=%0d want=%0d", lat, LAT); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        logic [162:0] aa, bb;
        logic [324:0] cc;
        int lat, extra;
        aa = rnd163(); bb = rnd163();
        start = 1'b1; a = aa; b = bb;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; cc = 'x;
        for (int n = 1; n <= 40; n++) begin
            if (done) begin lat = n; cc = c; break; end
            if (n == 3 || n == 10) begin start = 1'b1; a = rnd163(); b = rnd163(); end
            else start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        extra = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL ignore_latency got=%0d want=%0d", lat, LAT); end
        n_cmp++; if (cc !== ref_mul(aa, bb)) begin n_bad++; $display("FAIL ignore_result got=%h want=%h", cc, ref_mul(aa, bb)); end
        n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL ignore_extra_done got=%0d want=0", extra); end
    endtask

    task automatic test_back_to_back();
        logic [162:0] a1, b1, a2, b2;
        logic [324:0] c1, c2;
        int l1, l2, be1, be2;
        a1 = rnd163(); b1 = rnd163(); a2 = rnd163(); b2 = rnd163();
        do_op(a1, b1, c1, l1, be1);
        do_op(a2, b2, c2, l2, be2);
        n_cmp++; if (c1 !== ref_mul(a1, b1)) begin n_bad++; $display("FAIL b2b_first got=%h want=%h", c1, ref_mul(a1, b1)); end
        n_cmp++; if (c2 !== ref_mul(a2, b2)) begin n_bad++; $display("FAIL b2b_second got=%h want=%h", c2, ref_mul(a2, b2)); end
        n_cmp++; if (l2 !== LAT) begin n_bad++; $display("FAIL b2b_latency got=%0d want=%0d", l2, LAT); end
        n_cmp++; if (be2 !== 0) begin n_bad++; $display("FAIL b2b_busy errors=%0d want=0", be2); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int dn;
        start = 1'b1; a = rnd163() | 163'd1; b = rnd163() | 163'd1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n < 8; n++) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        n_cmp++; if (c !== '0) begin n_bad++; $display("FAIL midrst_c got=%h want=0", c); end
        dn = 0;
        for (int n = 0; n < 25; n++) begin
            if (done) dn++;
            @(posedge clk); #1;
        end
        n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL midrst_done got=%0d want=0", dn); end
        n_cmp++; if (c !== '0) begin n_bad++; $display("FAIL midrst_c_hold got=%h want=0", c); end
    endtask

    task automatic test_random();
        logic [162:0] aa, bb;
        logic [324:0] cc, exp;
        int lat, be;
        for (int t = 0; t < 1000; t++) begin
            aa = rnd163(); bb = rnd163();
            if (t == 0) begin aa = '1; bb = '1; end
            if (t == 1) aa = '0;
            do_op(aa, bb, cc, lat, be);
            exp = ref_mul(aa, bb);
            n_cmp++; if (cc !== exp) begin n_bad++; $display("FAIL random_%0d got=%h want=%h", t, cc, exp); end
            n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL random_lat_%0d got=%0d want=%0d", t, lat, LAT); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
